aes_ctr_axil_shell: RTL and testbench

- AXI4-Lite register front-end and CTR-mode sequencer for an external AES-192 block core.
- Part of the scannable AES-CTR subsystem, mapped at 0x44C0_0000.
- Holds three 192-bit keys, the plaintext, and the 128-bit counter state; launches the core and XORs the keystream with the plaintext to produce ciphertext.
- The AES round logic itself is outside this block.

---
 rtl/aes_ctr_axil_shell_if.sv | 64 ++++++
 rtl/aes_ctr_axil_shell.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_aes_ctr_axil_shell.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctr_axil_shell_if.sv
// ============================================================================
//  Module      : aes_ctr_axil_shell_if
//  Description : AXI4-Lite slave bus bundle for the AES-CTR register shell.
//                The master modport is the bus initiator; the slave modport
//                is the register shell.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aes_ctr_axil_shell_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]   s00_axi_awaddr;
    logic                    s00_axi_awvalid;
    logic                    s00_axi_awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   s00_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s00_axi_wstrb;
    logic                    s00_axi_wvalid;
    logic                    s00_axi_wready;
    // Write response channel
    logic [1:0]              s00_axi_bresp;
    logic                    s00_axi_bvalid;
    logic                    s00_axi_bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0]   s00_axi_araddr;
    logic                    s00_axi_arvalid;
    logic                    s00_axi_arready;
    // Read data channel
    logic [DATA_WIDTH-1:0]   s00_axi_rdata;
    logic [1:0]              s00_axi_rresp;
    logic                    s00_axi_rvalid;
    logic                    s00_axi_rready;

    modport master (
        output s00_axi_awaddr, s00_axi_awvalid,
        input  s00_axi_awready,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready
    );

    modport slave (
        input  s00_axi_awaddr, s00_axi_awvalid,
        output s00_axi_awready,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready
    );
endinterface

`default_nettype wire

// File: rtl/aes_ctr_axil_shell.sv
// ============================================================================
//  Module      : aes_ctr_axil_shell
//  Description : AXI4-Lite register front-end and CTR-mode sequencer for an
//                external AES-192 block core. Holds three keys, plaintext and
//                counter state, launches the core on a START rising edge and
//                XORs the returned keystream with the plaintext.
//                Optional macro CTR_AUTOINC_EN: increment the 128-bit counter
//                state after every completed block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_ctr_axil_shell #(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  wire                         s00_axi_aclk,
    input  wire                         s00_axi_aresetn,
    aes_ctr_axil_shell_if.slave         axi,
    output logic                        core_start,
    output logic [191:0]                core_key,
    output logic [127:0]                core_block,
    input  wire                         core_done,
    input  wire  [127:0]                core_result
);

    localparam int c_idx_w = C_S_AXI_ADDR_WIDTH - 2;

    // Word indices of the register map
    localparam int c_idx_start   = 0;
    localparam int c_idx_pt      = 1;
    localparam int c_idx_key0    = 5;
    localparam int c_idx_done    = 11;
    localparam int c_idx_ct      = 12;
    localparam int c_idx_st      = 16;
    localparam int c_idx_key1    = 20;
    localparam int c_idx_key2    = 26;
    localparam int c_idx_key_sel = 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } t_state;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic        r_start;
    logic [1:0]  r_key_sel;
    logic [31:0] r_pt   [4];
    logic [31:0] r_st   [4];
    logic [31:0] r_ct   [4];
    logic [31:0] r_key0 [6];
    logic [31:0] r_key1 [6];
    logic [31:0] r_key2 [6];
    logic        r_done;

    t_state      r_state;
    logic        r_core_start;
    logic [191:0] r_core_key;
    logic [127:0] r_core_block;

    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;
    logic               w_wr_en;
    logic               w_start_new;
    logic               w_start_edge;
    logic               w_done_accept;
    logic [191:0]       w_key0_flat;
    logic [191:0]       w_key1_flat;
    logic [191:0]       w_key2_flat;
    logic [191:0]       w_sel_key;
    logic [127:0]       w_st_flat;
    logic [127:0]       w_pt_flat;
    logic [31:0]        w_rd_data;
    logic               w_unused_addr;

    // Byte-lane merge of a write into an existing word
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Address decode and control strobes
    // ------------------------------------------------------------------
    assign w_wr_idx      = axi.s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx      = axi.s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    // Byte offset within a word does not affect decoding
    assign w_unused_addr = ^{axi.s00_axi_awaddr[1:0], axi.s00_axi_araddr[1:0]};

    // Handshake cycle: awready/wready are high and the master still holds valid
    assign w_wr_en       = r_awready && axi.s00_axi_awvalid && axi.s00_axi_wvalid;
    assign w_start_new   = axi.s00_axi_wstrb[0] ? axi.s00_axi_wdata[0] : r_start;
    assign w_start_edge  = w_wr_en && (int'(w_wr_idx) == c_idx_start)
                           && w_start_new && !r_start;
    assign w_done_accept = (r_state == S_BUSY) && core_done;

    // Flatten word arrays, word 0 in the least significant position
    always_comb begin
        w_key0_flat = '0;
        w_key1_flat = '0;
        w_key2_flat = '0;
        w_st_flat   = '0;
        w_pt_flat   = '0;
        for (int i = 0; i < 6; i++) begin
            w_key0_flat[i*32 +: 32] = r_key0[i];
            w_key1_flat[i*32 +: 32] = r_key1[i];
            w_key2_flat[i*32 +: 32] = r_key2[i];
        end
        for (int i = 0; i < 4; i++) begin
            w_st_flat[i*32 +: 32] = r_st[i];
            w_pt_flat[i*32 +: 32] = r_pt[i];
        end
    end

    // Key select; the reserved code 3 falls back to KEY0
    always_comb begin
        case (r_key_sel)
            2'd1:    w_sel_key = w_key1_flat;
            2'd2:    w_sel_key = w_key2_flat;
            default: w_sel_key = w_key0_flat;
        endcase
    end

`ifdef CTR_AUTOINC_EN
    logic         w_st_wr;
    logic [127:0] w_st_inc;
    assign w_st_wr  = w_wr_en && (int'(w_wr_idx) >= c_idx_st)
                      && (int'(w_wr_idx) < c_idx_st + 4);
    assign w_st_inc = w_st_flat + 128'd1;
`endif

    // ------------------------------------------------------------------
    // Write channel handshake: one accept per response
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            if (!r_awready && axi.s00_axi_awvalid && axi.s00_axi_wvalid && !r_bvalid) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && axi.s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Writable register file; RO and unmapped offsets fall through
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_start   <= 1'b0;
            r_key_sel <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_pt[i] <= '0;
                r_st[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                r_key0[i] <= '0;
                r_key1[i] <= '0;
                r_key2[i] <= '0;
            end
        end else begin
`ifdef CTR_AUTOINC_EN
            // A concurrent ST write wins over the increment
            if (w_done_accept && !w_st_wr) begin
                for (int i = 0; i < 4; i++) r_st[i] <= w_st_inc[i*32 +: 32];
            end
`endif
            if (w_wr_en) begin
                if (int'(w_wr_idx) == c_idx_start) r_start <= w_start_new;
                if (int'(w_wr_idx) == c_idx_key_sel && axi.s00_axi_wstrb[0])
                    r_key_sel <= axi.s00_axi_wdata[1:0];
                for (int i = 0; i < 4; i++) begin
                    if (int'(w_wr_idx) == c_idx_pt + i)
                        r_pt[i] <= f_merge(r_pt[i], axi.s00_axi_wdata, axi.s00_axi_wstrb);
                    if (int'(w_wr_idx) == c_idx_st + i)
                        r_st[i] <= f_merge(r_st[i], axi.s00_axi_wdata, axi.s00_axi_wstrb);
                end
                for (int i = 0; i < 6; i++) begin
                    if (int'(w_wr_idx) == c_idx_key0 + i)
                        r_key0[i] <= f_merge(r_key0[i], axi.s00_axi_wdata, axi.s00_axi_wstrb);
                    if (int'(w_wr_idx) == c_idx_key1 + i)
                        r_key1[i] <= f_merge(r_key1[i], axi.s00_axi_wdata, axi.s00_axi_wstrb);
                    if (int'(w_wr_idx) == c_idx_key2 + i)
                        r_key2[i] <= f_merge(r_key2[i], axi.s00_axi_wdata, axi.s00_axi_wstrb);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: launch on START edge, capture keystream XOR plaintext
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state      <= S_IDLE;
            r_core_start <= 1'b0;
            r_core_key   <= '0;
            r_core_block <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < 4; i++) r_ct[i] <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // core_done here is stale or spurious and is dropped
                    if (w_start_edge) begin
                        r_done       <= 1'b0;
                        r_core_start <= 1'b1;
                        r_core_key   <= w_sel_key;
                        r_core_block <= w_st_flat;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done_accept) begin
                        for (int i = 0; i < 4; i++)
                            r_ct[i] <= core_result[i*32 +: 32] ^ w_pt_flat[i*32 +: 32];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read data mux; unmapped offsets return 0
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        if (int'(w_rd_idx) == c_idx_start)   w_rd_data = {31'd0, r_start};
        if (int'(w_rd_idx) == c_idx_done)    w_rd_data = {31'd0, r_done};
        if (int'(w_rd_idx) == c_idx_key_sel) w_rd_data = {30'd0, r_key_sel};
        for (int i = 0; i < 4; i++) begin
            if (int'(w_rd_idx) == c_idx_pt + i) w_rd_data = r_pt[i];
            if (int'(w_rd_idx) == c_idx_ct + i) w_rd_data = r_ct[i];
            if (int'(w_rd_idx) == c_idx_st + i) w_rd_data = r_st[i];
        end
        for (int i = 0; i < 6; i++) begin
            if (int'(w_rd_idx) == c_idx_key0 + i) w_rd_data = r_key0[i];
            if (int'(w_rd_idx) == c_idx_key1 + i) w_rd_data = r_key1[i];
            if (int'(w_rd_idx) == c_idx_key2 + i) w_rd_data = r_key2[i];
        end
    end

    // ------------------------------------------------------------------
    // Read channel handshake: data registered on address accept
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= 1'b0;
            if (!r_arready && axi.s00_axi_arvalid && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (r_arready && axi.s00_axi_arvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && axi.s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axi.s00_axi_awready = r_awready;
    assign axi.s00_axi_wready  = r_wready;
    assign axi.s00_axi_bresp   = 2'b00;
    assign axi.s00_axi_bvalid  = r_bvalid;
    assign axi.s00_axi_arready = r_arready;
    assign axi.s00_axi_rdata   = r_rdata;
    assign axi.s00_axi_rresp   = 2'b00;
    assign axi.s00_axi_rvalid  = r_rvalid;

    assign core_start = r_core_start;
    assign core_key   = r_core_key;
    assign core_block = r_core_block;

endmodule

`default_nettype wire

// File: tb/tb_aes_ctr_axil_shell.sv
// ============================================================================
//  Module      : tb_aes_ctr_axil_shell
//  Description : Self-checking bench for aes_ctr_axil_shell with a stub AES
//                core and a register-map reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_ctr_axil_shell;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         core_start;
    logic [191:0] core_key;
    logic [127:0] core_block;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;

    int vectors = 0;
    int miscompares = 0;

    aes_ctr_axil_shell_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

    aes_ctr_axil_shell #(.C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .axi             (axi.slave),
        .core_start      (core_start),
        .core_key        (core_key),
        .core_block      (core_block),
        .core_done       (core_done),
        .core_result     (core_result)
    );

    always #5 clk = ~clk;

    // ---------------- stub AES core ----------------
    int           stub_lat = 12;
    logic [127:0] stub_res = '0;
    int           n_starts = 0;
    int           long_pulse = 0;
    logic [191:0] cap_key = '0;
    logic [127:0] cap_block = '0;
    int           inject_cnt = 0;
    int           inject_seen = 0;

    always @(negedge clk) begin
        if (core_start) begin
            n_starts++;
            cap_key   = core_key;
            cap_block = core_block;
            @(negedge clk);
            if (core_start) long_pulse++;
            repeat (stub_lat - 2) @(negedge clk);
            core_result = stub_res;
            core_done   = 1'b1;
            @(negedge clk);
            core_done   = 1'b0;
            core_result = '0;
        end else if (inject_cnt != inject_seen) begin
            inject_seen = inject_cnt;
            core_result = stub_res;
            core_done   = 1'b1;
            @(negedge clk);
            core_done   = 1'b0;
            core_result = '0;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]  m_reg [64];
    logic         m_busy;
    int           m_launches = 0;
    logic [191:0] exp_key;
    logic [127:0] exp_block;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = '0;
        m_busy = 1'b0;
    endfunction

    function automatic logic [127:0] m_vec128(input int base);
        return {m_reg[base+3], m_reg[base+2], m_reg[base+1], m_reg[base]};
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        int kb;
        logic [31:0] v;
        idx = int'(a[7:2]);
        if (idx == 11 || (idx >= 12 && idx <= 15) || idx > 32) return;
        v = m_reg[idx];
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        if (idx == 0)  v = v & 32'h1;
        if (idx == 32) v = v & 32'h3;
        if (idx == 0 && v[0] && !m_reg[0][0] && !m_busy) begin
            m_busy = 1'b1;
            m_launches++;
            m_reg[11] = '0;
            kb = (m_reg[32][1:0] == 2'd1) ? 20 : (m_reg[32][1:0] == 2'd2) ? 26 : 5;
            exp_key   = {m_reg[kb+5], m_reg[kb+4], m_reg[kb+3], m_reg[kb+2], m_reg[kb+1], m_reg[kb]};
            exp_block = m_vec128(16);
        end
        m_reg[idx] = v;
    endfunction

    function automatic void m_complete(input logic [127:0] res);
        logic [127:0] ct;
        logic [127:0] st;
        if (!m_busy) return;
        m_busy = 1'b0;
        ct = res ^ m_vec128(1);
        for (int i = 0; i < 4; i++) m_reg[12+i] = ct[i*32 +: 32];
        m_reg[11] = 32'd1;
`ifdef CTR_AUTOINC_EN
        st = m_vec128(16) + 128'd1;
`else
        st = m_vec128(16);
`endif
        for (int i = 0; i < 4; i++) m_reg[16+i] = st[i*32 +: 32];
    endfunction

    // ---------------- bus transport ----------------
    logic [1:0] last_bresp;
    logic [1:0] last_rresp;

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        axi.s00_axi_awaddr  = a;
        axi.s00_axi_awvalid = 1'b1;
        axi.s00_axi_wdata   = d;
        axi.s00_axi_wstrb   = s;
        axi.s00_axi_wvalid  = 1'b1;
        n = 0;
        while (!axi.s00_axi_awready && n < 20) begin @(negedge clk); n++; end
        if (!axi.s00_axi_awready) begin
            vectors++; miscompares++;
            $display("FAIL awready_timeout addr=%h got=0 required=1", a);
        end
        @(negedge clk);
        axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wvalid  = 1'b0;
        n = 0;
        while (!axi.s00_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        if (!axi.s00_axi_bvalid) begin
            vectors++; miscompares++;
            $display("FAIL bvalid_timeout addr=%h got=0 required=1", a);
        end
        last_bresp = axi.s00_axi_bresp;
        axi.s00_axi_bready = 1'b1;
        @(negedge clk);
        axi.s00_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        axi.s00_axi_araddr  = a;
        axi.s00_axi_arvalid = 1'b1;
        n = 0;
        while (!axi.s00_axi_arready && n < 20) begin @(negedge clk); n++; end
        if (!axi.s00_axi_arready) begin
            vectors++; miscompares++;
            $display("FAIL arready_timeout addr=%h got=0 required=1", a);
        end
        @(negedge clk);
        axi.s00_axi_arvalid = 1'b0;
        n = 0;
        while (!axi.s00_axi_rvalid && n < 20) begin @(negedge clk); n++; end
        if (!axi.s00_axi_rvalid) begin
            vectors++; miscompares++;
            $display("FAIL rvalid_timeout addr=%h got=0 required=1", a);
        end
        d = axi.s00_axi_rdata;
        last_rresp = axi.s00_axi_rresp;
        axi.s00_axi_rready = 1'b1;
        @(negedge clk);
        axi.s00_axi_rready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_write(a, d, s);
        m_write(a, d, s);
    endtask

    // Poll DONE until set, then retire the block in the model
    task automatic wait_done();
        logic [31:0] v;
        int n;
        v = '0;
        n = 0;
        while (v[0] !== 1'b1 && n < 60) begin axi_read(8'h2C, v); n++; end
        if (v[0] !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout got=%h required=1", v);
        end
        m_complete(stub_res);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        aresetn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (axi.s00_axi_bvalid !== 1'b0 || axi.s00_axi_rvalid !== 1'b0 || core_start !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs bvalid=%b rvalid=%b core_start=%b required=0",
                         axi.s00_axi_bvalid, axi.s00_axi_rvalid, core_start);
            end
        end
        aresetn = 1'b1;
        m_reset();
        axi_read(8'h2C, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_done got=%h required=0", v); end
        axi_read(8'h30, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_ct0 got=%h required=0", v); end
        axi_read(8'h80, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_keysel got=%h required=0", v); end
        vectors++;
        if (last_rresp !== 2'b00) begin miscompares++; $display("FAIL rresp got=%b required=00", last_rresp); end
    endtask

    task automatic test_roundtrip();
        logic [31:0] kw [6];
        logic [31:0] v;
        kw[0] = 32'h28aed2a6; kw[1] = 32'h2b7e1516; kw[2] = 32'h09cf4f3c;
        kw[3] = 32'habf71588; kw[4] = 32'h28aed2a6; kw[5] = 32'h2b7e1516;
        for (int i = 0; i < 6; i++) wr(8'(8'h14 + 4*i), kw[i], 4'hF);
        vectors++;
        if (last_bresp !== 2'b00) begin miscompares++; $display("FAIL bresp got=%b required=00", last_bresp); end
        for (int i = 0; i < 6; i++) begin
            axi_read(8'(8'h14 + 4*i), v); vectors++;
            if (v !== kw[i]) begin miscompares++; $display("FAIL key0_rt[%0d] got=%h required=%h", i, v, kw[i]); end
        end
        wr(8'h80, 32'h0, 4'hF);
        stub_lat = 6;
        stub_res = 128'h0;
        wr(8'h00, 32'h1, 4'hF);
        wait_done();
        vectors++;
        if (cap_key !== {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 32'h2b7e1516, 32'h28aed2a6}) begin
            miscompares++; $display("FAIL rt_core_key got=%h", cap_key);
        end
        wr(8'h00, 32'h0, 4'hF);
    endtask

    task automatic test_encrypt();
        int s0;
        logic [31:0] v;
        wr(8'h04, 32'h66667777, 4'hF); wr(8'h08, 32'h44445555, 4'hF);
        wr(8'h0C, 32'h22223333, 4'hF); wr(8'h10, 32'h00001111, 4'hF);
        wr(8'h40, 32'h3243f6a8, 4'hF); wr(8'h44, 32'h885a308d, 4'hF);
        wr(8'h48, 32'h313198a2, 4'hF); wr(8'h4C, 32'he0370734, 4'hF);
        stub_lat = 12;
        stub_res = {128{1'b1}};
        s0 = n_starts;
        long_pulse = 0;
        wr(8'h00, 32'h0, 4'hF); wr(8'h00, 32'h1, 4'hF); wr(8'h00, 32'h0, 4'hF);
        wait_done();
        vectors++;
        if (n_starts - s0 !== 1 || long_pulse !== 0) begin
            miscompares++; $display("FAIL enc_starts got=%0d long=%0d required=1,0", n_starts - s0, long_pulse);
        end
        vectors++;
        if (cap_block !== 128'he0370734_313198a2_885a308d_3243f6a8) begin
            miscompares++; $display("FAIL enc_block got=%h", cap_block);
        end
        axi_read(8'h30, v); vectors++;
        if (v !== 32'h99998888) begin miscompares++; $display("FAIL enc_ct0 got=%h required=99998888", v); end
        axi_read(8'h3C, v); vectors++;
        if (v !== 32'hFFFFEEEE) begin miscompares++; $display("FAIL enc_ct3 got=%h required=ffffeeee", v); end
    endtask

    task automatic test_key_sel();
        logic [2:0] sels [3];
        sels[0] = 3'd2; sels[1] = 3'd3; sels[2] = 3'd1;
        for (int i = 0; i < 6; i++) begin
            wr(8'(8'h50 + 4*i), $urandom, 4'hF);
            wr(8'(8'h68 + 4*i), m_reg[5+i] ^ 32'h5A5A0000 ^ $urandom_range(1, 255), 4'hF);
        end
        stub_lat = 5;
        foreach (sels[k]) begin
            wr(8'h80, {29'd0, sels[k]}, 4'hF);
            wr(8'h00, 32'h0, 4'hF);
            wr(8'h00, 32'h1, 4'hF);
            wait_done();
            vectors++;
            if (cap_key !== exp_key) begin
                miscompares++; $display("FAIL keysel_%0d got=%h required=%h", sels[k], cap_key, exp_key);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [31:0] v;
        stub_lat = 40;
        stub_res = {$urandom, $urandom, $urandom, $urandom};
        s0 = n_starts;
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h00, 32'h1, 4'hF);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h00, 32'h1, 4'hF);
        wr(8'h40, $urandom, 4'hF);
        wait_done();
        vectors++;
        if (n_starts - s0 !== 1 || n_starts !== m_launches) begin
            miscompares++; $display("FAIL busy_starts got=%0d required=1", n_starts - s0);
        end
        vectors++;
        if (cap_block !== exp_block) begin miscompares++; $display("FAIL busy_block got=%h required=%h", cap_block, exp_block); end
        wr(8'h00, 32'h1, 4'hF);
        repeat (20) @(negedge clk);
        vectors++;
        if (n_starts !== m_launches) begin
            miscompares++; $display("FAIL level_start got=%0d required=%0d", n_starts, m_launches);
        end
        axi_read(8'h2C, v); vectors++;
        if (v !== m_reg[11]) begin miscompares++; $display("FAIL busy_done got=%h required=%h", v, m_reg[11]); end
    endtask

    task automatic test_done_in_idle();
        logic [31:0] v;
        stub_res = {$urandom, $urandom, $urandom, $urandom};
        inject_cnt++;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(8'h30 + 4*i), v); vectors++;
            if (v !== m_reg[12+i]) begin miscompares++; $display("FAIL idle_done_ct[%0d] got=%h required=%h", i, v, m_reg[12+i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [7:0]  a;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 4; i++) begin
                wr(8'(8'h04 + 4*i), $urandom, 4'($urandom_range(1, 15)));
                wr(8'(8'h40 + 4*i), $urandom, 4'($urandom_range(1, 15)));
            end
            for (int i = 0; i < 3; i++) wr(8'(8'h14 + 4*$urandom_range(0, 5) + 8'h3C*$urandom_range(0, 1)), $urandom, 4'hF);
            wr(8'h80, $urandom, 4'hF);
            a = 8'(8'h84 + 4*$urandom_range(0, 30));
            wr(a, $urandom, 4'hF);
            wr(8'h30, $urandom, 4'hF);
            axi_read(a, v); vectors++;
            if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped addr=%h got=%h required=0", a, v); end
            stub_lat = $urandom_range(2, 25);
            stub_res = {$urandom, $urandom, $urandom, $urandom};
            wr(8'h00, 32'h0, 4'hF);
            wr(8'h00, 32'h1, 4'hF);
            wait_done();
            vectors++;
            if (cap_key !== exp_key || cap_block !== exp_block || n_starts !== m_launches) begin
                miscompares++;
                $display("FAIL rand_launch it=%0d key=%h block=%h starts=%0d required key=%h block=%h starts=%0d",
                         it, cap_key, cap_block, n_starts, exp_key, exp_block, m_launches);
            end
            for (int i = 0; i < 4; i++) begin
                axi_read(8'(8'h30 + 4*i), v); vectors++;
                if (v !== m_reg[12+i]) begin miscompares++; $display("FAIL rand_ct[%0d] got=%h required=%h", i, v, m_reg[12+i]); end
                axi_read(8'(8'h40 + 4*i), v); vectors++;
                if (v !== m_reg[16+i]) begin miscompares++; $display("FAIL rand_st[%0d] got=%h required=%h", i, v, m_reg[16+i]); end
            end
            axi_read(8'h80, v); vectors++;
            if (v !== m_reg[32]) begin miscompares++; $display("FAIL rand_keysel got=%h required=%h", v, m_reg[32]); end
        end
    endtask

    task automatic test_autoinc();
        logic [31:0] v;
        logic [31:0] want;
        for (int i = 0; i < 4; i++) wr(8'(8'h40 + 4*i), 32'hFFFF_FFFF, 4'hF);
        stub_lat = 4;
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h00, 32'h1, 4'hF);
        wait_done();
`ifdef CTR_AUTOINC_EN
        want = 32'h0;
`else
        want = 32'hFFFF_FFFF;
`endif
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(8'h40 + 4*i), v); vectors++;
            if (v !== want) begin miscompares++; $display("FAIL autoinc_st[%0d] got=%h required=%h", i, v, want); end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] v;
        stub_lat = 15;
        stub_res = {128{1'b1}};
        wr(8'h04, 32'h12345678, 4'hF);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h00, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        m_reset();
        repeat (20) @(negedge clk);
        axi_read(8'h2C, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL midop_done got=%h required=0", v); end
        axi_read(8'h30, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL midop_ct0 got=%h required=0", v); end
        axi_read(8'h04, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL midop_pt0 got=%h required=0", v); end
    endtask

    initial begin
        axi.s00_axi_awaddr  = '0;
        axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wdata   = '0;
        axi.s00_axi_wstrb   = '0;
        axi.s00_axi_wvalid  = 1'b0;
        axi.s00_axi_bready  = 1'b0;
        axi.s00_axi_araddr  = '0;
        axi.s00_axi_arvalid = 1'b0;
        axi.s00_axi_rready  = 1'b0;
        m_reset();
        test_reset();
        test_roundtrip();
        test_encrypt();
        test_key_sel();
        test_back_to_back();
        test_done_in_idle();
        test_random();
        test_autoinc();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
